// File: rtl/core_pkg.sv
// core_pkg: shared constants, fill/drain state encoding, error bit indices and range check for the pixel path
package core_pkg;
  localparam int DEPTH = 192;
  localparam int WR_BEATS = 48;
  localparam int RD_BEATS = 64;
  localparam int ERR_WR = 0;
  localparam int ERR_RD = 1;
  localparam int ERR_ADDR = 2;
  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;
  function automatic logic in_range(input logic [7:0] a);
    return a < 8'(DEPTH);
  endfunction
endpackage

// File: rtl/core_pixel_ram.sv
// core_pixel_ram: DEPTH x 8 storage; ports I_WE/I_WA/I_WD = 4 byte-write lanes, I_RA/O_RD = 3 async byte reads (out-of-range reads 0)
module core_pixel_ram import core_pkg::*; (
  input  logic        I_HCLK,
  input  logic [3:0]  I_WE,
  input  logic [31:0] I_WA,
  input  logic [31:0] I_WD,
  input  logic [23:0] I_RA,
  output logic [23:0] O_RD
);
  logic [7:0] mem [DEPTH];
  // lanes applied in ascending order so the highest lane wins on duplicate addresses
  always_ff @(posedge I_HCLK)
    for (int k = 0; k < 4; k++)
      if (I_WE[k]) mem[I_WA[8*k+:8]] <= I_WD[8*k+:8];
  always_comb begin
    O_RD = '0;
    for (int j = 0; j < 3; j++)
      O_RD[8*j+:8] = in_range(I_RA[8*j+:8]) ? mem[I_RA[8*j+:8]] : 8'h00;
  end
endmodule

// File: rtl/core_pixel_buffer.sv
// core_pixel_buffer: 192-byte RGB staging buffer; 4-lane byte writes in FILL, registered RGB pixel reads in DRAIN, counts and sticky O_ERR
module core_pixel_buffer import core_pkg::*; (
  input  logic        I_HCLK,
  input  logic        I_HRESET,
  input  logic        I_CLEAR,
  input  logic        I_WR_EN,
  input  logic [7:0]  I_WR_ADDR0,
  input  logic [7:0]  I_WR_ADDR1,
  input  logic [7:0]  I_WR_ADDR2,
  input  logic [7:0]  I_WR_ADDR3,
  input  logic [31:0] I_WR_DATA,
  output logic        O_WR_READY,
  input  logic        I_RD_EN,
  input  logic [7:0]  I_RD_ADDRR,
  input  logic [7:0]  I_RD_ADDRG,
  input  logic [7:0]  I_RD_ADDRB,
  output logic        O_RD_READY,
  output logic [23:0] O_RD_DATA,
  output logic        O_RD_VALID,
  output logic [5:0]  O_WR_COUNT,
  output logic [6:0]  O_RD_COUNT,
  output logic [2:0]  O_ERR
);
  state_t state;
  logic wr_acc, rd_acc, wr_last, rd_last;
  logic [3:0] wr_ok;
  logic [2:0] rd_ok, err_set;
  logic [23:0] ram_rd;
  assign O_WR_READY = state == FILL;
  assign O_RD_READY = state == DRAIN;
  always_comb begin
    wr_acc = I_WR_EN & O_WR_READY;
    rd_acc = I_RD_EN & O_RD_READY;
    wr_ok = {in_range(I_WR_ADDR3), in_range(I_WR_ADDR2), in_range(I_WR_ADDR1), in_range(I_WR_ADDR0)};
    rd_ok = {in_range(I_RD_ADDRR), in_range(I_RD_ADDRG), in_range(I_RD_ADDRB)};
    wr_last = wr_acc & (O_WR_COUNT == 6'(WR_BEATS - 1));
    rd_last = rd_acc & (O_RD_COUNT == 7'(RD_BEATS - 1));
    err_set = '0;
    err_set[ERR_WR] = I_WR_EN & ~wr_acc;
    err_set[ERR_RD] = I_RD_EN & ~rd_acc;
    err_set[ERR_ADDR] = (wr_acc & ~&wr_ok) | (rd_acc & ~&rd_ok);
  end
  core_pixel_ram u_ram (
    .I_HCLK (I_HCLK),
    .I_WE   ({4{wr_acc & ~I_CLEAR}} & wr_ok),
    .I_WA   ({I_WR_ADDR3, I_WR_ADDR2, I_WR_ADDR1, I_WR_ADDR0}),
    .I_WD   (I_WR_DATA),
    .I_RA   ({I_RD_ADDRR, I_RD_ADDRG, I_RD_ADDRB}),
    .O_RD   (ram_rd)
  );
  // a clear cycle is fully discarded, including any error it would otherwise flag
  always_ff @(posedge I_HCLK or posedge I_HRESET)
    if (I_HRESET) begin
      state <= FILL;
      O_WR_COUNT <= '0;
      O_RD_COUNT <= '0;
      O_RD_DATA <= '0;
      O_RD_VALID <= 1'b0;
      O_ERR <= '0;
    end else if (I_CLEAR) begin
      state <= FILL;
      O_WR_COUNT <= '0;
      O_RD_COUNT <= '0;
      O_RD_VALID <= 1'b0;
    end else begin
      state <= wr_last ? DRAIN : rd_last ? FILL : state;
      O_WR_COUNT <= wr_last ? 6'd0 : O_WR_COUNT + 6'(wr_acc);
      O_RD_COUNT <= rd_last ? 7'd0 : O_RD_COUNT + 7'(rd_acc);
      O_RD_DATA <= rd_acc ? ram_rd : O_RD_DATA;
      O_RD_VALID <= rd_acc;
      O_ERR <= O_ERR | err_set;
    end
endmodule

// File: tb/tb_core_pixel_buffer.sv
// tb_core_pixel_buffer: scoreboard bench for core_pixel_buffer fill/drain, errors, clear and async reset
module tb_core_pixel_buffer;
  import core_pkg::*;
  logic I_HCLK = 1'b0;
  logic I_HRESET = 1'b1, I_CLEAR = 1'b0, I_WR_EN = 1'b0, I_RD_EN = 1'b0;
  logic [7:0] I_WR_ADDR0 = '0, I_WR_ADDR1 = '0, I_WR_ADDR2 = '0, I_WR_ADDR3 = '0;
  logic [7:0] I_RD_ADDRR = '0, I_RD_ADDRG = '0, I_RD_ADDRB = '0;
  logic [31:0] I_WR_DATA = '0;
  logic O_WR_READY, O_RD_READY, O_RD_VALID;
  logic [23:0] O_RD_DATA;
  logic [5:0] O_WR_COUNT;
  logic [6:0] O_RD_COUNT;
  logic [2:0] O_ERR;
  int tests = 0, fails = 0;
  logic [23:0] exp_q [$];
  logic [7:0] model [DEPTH];

  core_pixel_buffer dut (
    .I_HCLK(I_HCLK), .I_HRESET(I_HRESET), .I_CLEAR(I_CLEAR),
    .I_WR_EN(I_WR_EN), .I_WR_ADDR0(I_WR_ADDR0), .I_WR_ADDR1(I_WR_ADDR1),
    .I_WR_ADDR2(I_WR_ADDR2), .I_WR_ADDR3(I_WR_ADDR3), .I_WR_DATA(I_WR_DATA),
    .O_WR_READY(O_WR_READY), .I_RD_EN(I_RD_EN), .I_RD_ADDRR(I_RD_ADDRR),
    .I_RD_ADDRG(I_RD_ADDRG), .I_RD_ADDRB(I_RD_ADDRB), .O_RD_READY(O_RD_READY),
    .O_RD_DATA(O_RD_DATA), .O_RD_VALID(O_RD_VALID), .O_WR_COUNT(O_WR_COUNT),
    .O_RD_COUNT(O_RD_COUNT), .O_ERR(O_ERR)
  );

  always #5 I_HCLK = ~I_HCLK;

  always @(negedge I_HCLK)
    if (O_RD_VALID) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL rd_unexpected_valid data=%h expected no valid", O_RD_DATA);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        if (O_RD_DATA !== e) begin
          fails++;
          $display("FAIL rd_data got=%h exp=%h", O_RD_DATA, e);
        end
      end
    end

  task automatic tick;
    @(posedge I_HCLK);
    #1;
  endtask

  function automatic logic [7:0] mbyte(input logic [7:0] a);
    return a < 8'(DEPTH) ? model[a] : 8'h00;
  endfunction

  task automatic wr_beat(input logic [7:0] a0, a1, a2, a3, input logic [31:0] d);
    logic [7:0] a [4];
    a = '{a0, a1, a2, a3};
    I_WR_EN = 1'b1;
    {I_WR_ADDR3, I_WR_ADDR2, I_WR_ADDR1, I_WR_ADDR0} = {a3, a2, a1, a0};
    I_WR_DATA = d;
    for (int k = 0; k < 4; k++)
      if (a[k] < 8'(DEPTH)) model[a[k]] = d[8*k+:8];
    tick();
    I_WR_EN = 1'b0;
  endtask

  task automatic pattern_beat(input int n, input logic [7:0] x);
    logic [7:0] b [4];
    for (int k = 0; k < 4; k++) b[k] = 8'(4*n + k);
    wr_beat(b[0], b[1], b[2], b[3], {b[3] ^ x, b[2] ^ x, b[1] ^ x, b[0] ^ x});
  endtask

  task automatic rd_pix(input logic [7:0] r, g, b);
    I_RD_EN = 1'b1;
    {I_RD_ADDRR, I_RD_ADDRG, I_RD_ADDRB} = {r, g, b};
    exp_q.push_back({mbyte(r), mbyte(g), mbyte(b)});
    tick();
    I_RD_EN = 1'b0;
  endtask

  task automatic test_reset;
    I_HRESET = 1'b1;
    tick();
    tick();
    tests++;
    if ({O_WR_READY, O_RD_READY, O_RD_VALID, O_WR_COUNT, O_RD_COUNT, O_ERR, O_RD_DATA} !== {1'b1, 1'b0, 1'b0, 6'd0, 7'd0, 3'd0, 24'd0}) begin
      fails++;
      $display("FAIL reset_state wr_rdy=%b rd_rdy=%b vld=%b wc=%0d rc=%0d err=%b data=%h", O_WR_READY, O_RD_READY, O_RD_VALID, O_WR_COUNT, O_RD_COUNT, O_ERR, O_RD_DATA);
    end
    I_HRESET = 1'b0;
  endtask

  task automatic test_fill;
    for (int n = 0; n < WR_BEATS; n++) begin
      wr_beat(8'(4*n), 8'(4*n+1), 8'(4*n+2), 8'(4*n+3), {8'(4*n+3), 8'(4*n+2), 8'(4*n+1), 8'(4*n)});
      tests++;
      if (O_WR_COUNT !== 6'((n + 1) % WR_BEATS)) begin
        fails++;
        $display("FAIL fill_count beat=%0d got=%0d exp=%0d", n, O_WR_COUNT, (n + 1) % WR_BEATS);
      end
    end
    tests++;
    if (O_RD_READY !== 1'b1 || O_WR_READY !== 1'b0) begin
      fails++;
      $display("FAIL fill_to_drain rd_rdy=%b wr_rdy=%b exp 1/0", O_RD_READY, O_WR_READY);
    end
  endtask

  task automatic test_drain;
    for (int p = 0; p < RD_BEATS; p++) begin
      rd_pix(8'(3*p), 8'(3*p+1), 8'(3*p+2));
      tests++;
      if (exp_q[exp_q.size()-1] !== {8'(3*p), 8'(3*p+1), 8'(3*p+2)}) begin
        fails++;
        $display("FAIL drain_model pix=%0d got=%h", p, exp_q[exp_q.size()-1]);
      end
      if (p % 16 == 15) begin
        tests++;
        if (O_RD_COUNT !== 7'((p + 1) % RD_BEATS)) begin
          fails++;
          $display("FAIL drain_count pix=%0d got=%0d exp=%0d", p, O_RD_COUNT, (p + 1) % RD_BEATS);
        end
      end
    end
    tests++;
    if (O_WR_READY !== 1'b1 || O_RD_READY !== 1'b0) begin
      fails++;
      $display("FAIL drain_to_fill wr_rdy=%b rd_rdy=%b exp 1/0", O_WR_READY, O_RD_READY);
    end
    tick();
    tests++;
    if (exp_q.size() != 0 || O_RD_DATA !== 24'hBDBEBF || O_RD_VALID !== 1'b0) begin
      fails++;
      $display("FAIL drain_tail pending=%0d data=%h vld=%b exp 0/bdbebf/0", exp_q.size(), O_RD_DATA, O_RD_VALID);
    end
  endtask

  task automatic test_oor_write;
    wr_beat(8'd0, 8'd1, 8'd2, 8'hC0, 32'hAABBCCDD);
    tests++;
    if (O_WR_COUNT !== 6'd1 || O_ERR !== 3'b100) begin
      fails++;
      $display("FAIL oor_write wc=%0d err=%b exp 1/100", O_WR_COUNT, O_ERR);
    end
    for (int n = 1; n < WR_BEATS; n++) pattern_beat(n, 8'h5A);
    rd_pix(8'd0, 8'd1, 8'd2);
    tests++;
    if (exp_q[exp_q.size()-1] !== 24'hDDCCBB) begin
      fails++;
      $display("FAIL oor_model got=%h exp=ddccbb", exp_q[exp_q.size()-1]);
    end
    rd_pix(8'd3, 8'd4, 8'hFF);
    tests++;
    if (exp_q[exp_q.size()-1] !== {8'd3, 8'd4 ^ 8'h5A, 8'h00}) begin
      fails++;
      $display("FAIL oor_read_model got=%h", exp_q[exp_q.size()-1]);
    end
  endtask

  task automatic test_rejects;
    I_WR_EN = 1'b1;
    tick();
    I_WR_EN = 1'b0;
    tests++;
    if (O_WR_COUNT !== 6'd0 || O_RD_COUNT !== 7'd2 || O_ERR[ERR_WR] !== 1'b1) begin
      fails++;
      $display("FAIL wr_in_drain wc=%0d rc=%0d err=%b exp 0/2/x_1", O_WR_COUNT, O_RD_COUNT, O_ERR);
    end
    for (int p = 2; p < RD_BEATS; p++) rd_pix(8'(3*p), 8'(3*p+1), 8'(3*p+2));
    tick();
    for (int n = 0; n < 10; n++) pattern_beat(n, 8'hC3);
    I_RD_EN = 1'b1;
    tick();
    I_RD_EN = 1'b0;
    tests++;
    if (O_WR_COUNT !== 6'd10 || O_RD_COUNT !== 7'd0 || O_RD_VALID !== 1'b0 || O_ERR !== 3'b111) begin
      fails++;
      $display("FAIL rd_in_fill wc=%0d rc=%0d vld=%b err=%b exp 10/0/0/111", O_WR_COUNT, O_RD_COUNT, O_RD_VALID, O_ERR);
    end
    tick();
  endtask

  task automatic test_clear;
    for (int n = 10; n < WR_BEATS - 1; n++) pattern_beat(n, 8'hC3);
    tests++;
    if (O_WR_COUNT !== 6'd47) begin
      fails++;
      $display("FAIL clear_setup wc=%0d exp 47", O_WR_COUNT);
    end
    I_CLEAR = 1'b1;
    I_WR_EN = 1'b1;
    tick();
    I_CLEAR = 1'b0;
    I_WR_EN = 1'b0;
    tests++;
    if (O_WR_COUNT !== 6'd0 || O_WR_READY !== 1'b1 || O_RD_READY !== 1'b0 || O_ERR !== 3'b111) begin
      fails++;
      $display("FAIL clear_write wc=%0d wr_rdy=%b rd_rdy=%b err=%b exp 0/1/0/111", O_WR_COUNT, O_WR_READY, O_RD_READY, O_ERR);
    end
    tick();
    tests++;
    if (O_RD_READY !== 1'b0) begin
      fails++;
      $display("FAIL clear_hold rd_rdy=%b exp 0", O_RD_READY);
    end
  endtask

  task automatic test_async_reset;
    for (int n = 0; n < WR_BEATS; n++) pattern_beat(n, 8'h77);
    for (int p = 0; p < 30; p++) rd_pix(8'(3*p+2), 8'(3*p), 8'(3*p+1));
    tick();
    tests++;
    if (O_RD_COUNT !== 7'd30 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL areset_setup rc=%0d pending=%0d exp 30/0", O_RD_COUNT, exp_q.size());
    end
    #1 I_HRESET = 1'b1;
    #1;
    tests++;
    if ({O_WR_READY, O_RD_READY, O_RD_VALID, O_WR_COUNT, O_RD_COUNT, O_ERR, O_RD_DATA} !== {1'b1, 1'b0, 1'b0, 6'd0, 7'd0, 3'd0, 24'd0}) begin
      fails++;
      $display("FAIL areset wr_rdy=%b rd_rdy=%b vld=%b wc=%0d rc=%0d err=%b data=%h", O_WR_READY, O_RD_READY, O_RD_VALID, O_WR_COUNT, O_RD_COUNT, O_ERR, O_RD_DATA);
    end
    #1 I_HRESET = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_oor_write();
    test_rejects();
    test_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/core_pixel_buffer.md
Name: core_pixel_buffer

Overview:
- 192-byte single-image staging buffer (8x8 pixels, RGB, 3 bytes/pixel) that sits directly downstream of the pixel address generator.
- Filled from the AHB/DMA side one 32-bit beat at a time, at the four byte addresses ADDR0..ADDR3 supplied by the generator.
- Drained toward the output memory one RGB pixel at a time, at the three byte addresses ADDRR/G/B supplied by the generator.
- A fill/drain state machine enforces strict alternation: no reads of a partially filled image, no overwrite of an undrained image.

Parameters:
DEPTH, 192, storage size in bytes
WR_BEATS, 48, accepted write beats that make the buffer full (DEPTH/4)
RD_BEATS, 64, accepted read beats that empty the buffer (DEPTH/3)

Ports:
I_HCLK  in  1  clock, all state on rising edge
I_HRESET  in  1  reset, asynchronous, active-high
I_CLEAR  in  1  synchronous abort: return to FILL, zero the counters
I_WR_EN  in  1  write request
I_WR_ADDR0..I_WR_ADDR3  in  8 each  byte address for lanes 0..3
I_WR_DATA  in  32  lane k = bits [8k+7:8k]
O_WR_READY  out  1  high in FILL
I_RD_EN  in  1  read request
I_RD_ADDRR, I_RD_ADDRG, I_RD_ADDRB  in  8 each  byte addresses for R, G, B
O_RD_READY  out  1  high in DRAIN
O_RD_DATA  out  24  {R[23:16], G[15:8], B[7:0]}, registered
O_RD_VALID  out  1  one-cycle pulse, O_RD_DATA valid
O_WR_COUNT  out  6  accepted write beats in the current fill
O_RD_COUNT  out  7  accepted read beats in the current drain
O_ERR  out  3  sticky: [0] write while not ready, [1] read while not ready, [2] address >= DEPTH

Behaviour:
- Clock and reset: one clock (I_HCLK). Reset (I_HRESET) is asynchronous and active-high.
- Reset values:
  - state = FILL, so O_WR_READY=1 and O_RD_READY=0.
  - O_RD_DATA=0, O_RD_VALID=0, both counts 0, O_ERR=0.
  - Storage array is not reset.
- States: FILL and DRAIN (1-bit state register).
- Write accept: wr_acc = I_WR_EN & O_WR_READY.
  - On accept, each lane with address < DEPTH writes its byte.
  - Lanes with address >= DEPTH are dropped and set O_ERR[2]; the beat still counts.
- FILL -> DRAIN: on the accepted write that makes O_WR_COUNT reach WR_BEATS.
  - O_WR_COUNT returns to 0 in that same edge; O_RD_READY rises the next cycle.
- Read accept: rd_acc = I_RD_EN & O_RD_READY.
  - Latency is 1: O_RD_DATA and O_RD_VALID update on the edge after acceptance.
  - An out-of-range byte address reads 0x00 and sets O_ERR[2].
  - With no accept, O_RD_DATA holds its value and O_RD_VALID=0.
- DRAIN -> FILL: on the accepted read that makes O_RD_COUNT reach RD_BEATS.
  - O_RD_COUNT returns to 0 in that edge.
  - The O_RD_VALID for that last read still pulses on the following cycle.
- Rejected requests:
  - I_WR_EN in DRAIN is ignored and sets O_ERR[0].
  - I_RD_EN in FILL is ignored and sets O_ERR[1].
- Address collisions:
  - Duplicate lane addresses within one write beat: the highest-numbered lane wins.
  - Writes and reads never overlap in time, so there is no read/write collision.
- I_CLEAR:
  - Forces FILL, zeroes both counts and O_RD_VALID.
  - Keeps storage and O_ERR unchanged.
  - Has priority over a same-cycle accept; that write or read is discarded.
  - O_ERR clears only on I_HRESET.
- Reset asserted mid-fill or mid-drain: immediate return to the reset values. The partially written contents are undefined to the consumer.
- Width rules: counts are unsigned and compare with ==. Address comparison is 8-bit unsigned against DEPTH.

Decomposition:
- Shared package (core_pkg): DEPTH, WR_BEATS, RD_BEATS, FILL/DRAIN state encodings, and the O_ERR bit indices. The address generator uses the same constants.
- One natural sub-module, core_pixel_ram: 192x8 array with 4 byte-write ports and 3 async byte-read ports. The read register lives in core_pixel_buffer.

Test Plan:
- Reset, then 48 writes:
  - Beat n: addresses 4n..4n+3, data {4n+3,4n+2,4n+1,4n}.
  - Required: O_RD_READY=1 on the cycle after beat 48; O_WR_COUNT=0.
- Drain after that fill:
  - Read R=3p, G=3p+1, B=3p+2 for p=0..63.
  - Required: O_RD_DATA = {3p,3p+1,3p+2} one cycle after each accept.
  - Required: O_WR_READY=1 the cycle after read 64.
- Out-of-range write:
  - Write with I_WR_ADDR3=8'hC0 during fill.
  - Required: lanes 0-2 stored, O_ERR=3'b100, O_WR_COUNT still increments.
- Read during FILL (count 10) and write during DRAIN:
  - Required: no count change, no O_RD_VALID, O_ERR[1:0]=2'b11.
- I_CLEAR together with a write at O_WR_COUNT=47:
  - Required: state stays FILL, O_WR_COUNT=0, O_RD_READY stays 0.
- I_HRESET pulsed asynchronously mid-drain (O_RD_COUNT=30):
  - Required: outputs reach their reset values before the next clock edge, with O_WR_READY=1.
